// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared encodings and defaults for the fetch sequencing controller.
// Imported by the controller and its counter sub-module.
package fetch_seq_ctrl_pkg;

  localparam int FLUSH_DEPTH_DEF = 3;
  localparam int FLUSH_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Pipeline-side signal bundle of the fetch sequencing controller.
// The master modport belongs to the pipeline, the slave modport to the controller.
interface fetch_seq_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_target_i;
  logic              stall_req_i;
  logic              halt_i;
  logic              resume_i;
  logic              pc_en_o;
  logic              if_valid_o;
  logic              flush_o;
  logic              halted_o;
  logic [1:0]        state_o;
  logic [ADDR_W-1:0] last_target_o;
  logic [CNT_W-1:0]  redirect_cnt_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output redirect_i, redirect_target_i, stall_req_i, halt_i, resume_i,
    input  pc_en_o, if_valid_o, flush_o, halted_o, state_o,
           last_target_o, redirect_cnt_o, stall_cnt_o
  );

  modport slave (
    input  redirect_i, redirect_target_i, stall_req_i, halt_i, resume_i,
    output pc_en_o, if_valid_o, flush_o, halted_o, state_o,
           last_target_o, redirect_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/fetch_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Used for the redirect and stall performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc_en,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencing controller: PC enable, fetch-valid, wrong-path
// flush after a redirect, HALT/resume handling and saturating perf counters.
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
  parameter int CNT_W       = 16
) (
  input logic             clk,
  input logic             rst,
  fetch_seq_ctrl_if.slave bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
    (FLUSH_DEPTH > 0) ? FLUSH_CNT_W'(FLUSH_DEPTH - 1) : '0;

  state_e                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
  logic [ADDR_W-1:0]      last_target_q, last_target_d;

  logic in_run, in_flush, in_halt;
  logic redirect_acc, stall_cnt_en;

  assign in_run   = (state_q == ST_RUN);
  assign in_flush = (state_q == ST_FLUSH);
  assign in_halt  = (state_q == ST_HALT);

  // Redirects and halts seen outside RUN come from killed instructions.
  assign redirect_acc = in_run & bus.redirect_i & ~bus.halt_i;
  assign stall_cnt_en = bus.stall_req_i & ~in_halt;

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    last_target_d = last_target_q;
    if (rst) begin
      state_d       = ST_RUN;
      fcnt_d        = '0;
      last_target_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.halt_i) begin
            state_d = ST_HALT;
          end else if (bus.redirect_i) begin
            last_target_d = bus.redirect_target_i;
            if (FLUSH_DEPTH > 0) begin
              state_d = ST_FLUSH;
              fcnt_d  = FLUSH_LOAD;
            end
          end
        end
        ST_FLUSH: begin
          if (!bus.stall_req_i) begin
            if (fcnt_q == '0) state_d = ST_RUN;
            else              fcnt_d  = fcnt_q - FLUSH_CNT_W'(1);
          end
        end
        ST_HALT: begin
          if (bus.resume_i) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    fcnt_q        <= fcnt_d;
    last_target_q <= last_target_d;
  end

  // Moore flags decode straight from the state flop; pc_en must react to a stall in-cycle.
  assign bus.if_valid_o    = in_run;
  assign bus.flush_o       = in_flush;
  assign bus.halted_o      = in_halt;
  assign bus.state_o       = state_q;
  assign bus.last_target_o = last_target_q;
  assign bus.pc_en_o       = (in_run | in_flush) & ~bus.stall_req_i & ~(in_run & bus.halt_i);

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk    (clk),
    .clr    (rst),
    .inc_en (redirect_acc),
    .cnt_o  (bus.redirect_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .clr    (rst),
    .inc_en (stall_cnt_en),
    .cnt_o  (bus.stall_cnt_o)
  );

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Scoreboard bench for fetch_seq_ctrl: a FLUSH_DEPTH=3 instance against a cycle
// model, plus a FLUSH_DEPTH=0 instance driven into redirect-counter saturation.
module tb_fetch_seq_ctrl;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_seq_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus3 ();
  fetch_seq_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus0 ();

  fetch_seq_ctrl #(.ADDR_W(ADDR_W), .FLUSH_DEPTH(DEPTH), .CNT_W(CNT_W)) dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  fetch_seq_ctrl #(.ADDR_W(ADDR_W), .FLUSH_DEPTH(0), .CNT_W(CNT_W)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  typedef struct {
    logic              pc_en;
    logic              if_valid;
    logic              flush;
    logic              halted;
    logic [1:0]        state;
    logic [ADDR_W-1:0] last_target;
    logic [CNT_W-1:0]  rcnt;
    logic [CNT_W-1:0]  scnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model of the DEPTH=3 controller (0=RUN, 1=FLUSH, 2=HALT).
  int                m_state;
  int                m_fcnt;
  logic [ADDR_W-1:0] m_last;
  logic [CNT_W-1:0]  m_rcnt;
  logic [CNT_W-1:0]  m_scnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_fcnt  = 0;
    m_last  = '0;
    m_rcnt  = '0;
    m_scnt  = '0;
  endtask

  // One clock cycle: drive, push expectation, compare at negedge, advance model.
  task automatic step(input logic redir, input logic [ADDR_W-1:0] tgt, input logic stall,
                      input logic halt, input logic resume, input logic do_rst);
    exp_t e;
    bus3.redirect_i        = redir;
    bus3.redirect_target_i = tgt;
    bus3.stall_req_i       = stall;
    bus3.halt_i            = halt;
    bus3.resume_i          = resume;
    rst                    = do_rst;

    e.pc_en       = (m_state != 2) && !stall && !(m_state == 0 && halt);
    e.if_valid    = (m_state == 0);
    e.flush       = (m_state == 1);
    e.halted      = (m_state == 2);
    e.state       = 2'(m_state);
    e.last_target = m_last;
    e.rcnt        = m_rcnt;
    e.scnt        = m_scnt;
    sb_q.push_back(e);

    @(negedge clk);
    e = sb_q.pop_front();
    check("pc_en",       32'(bus3.pc_en_o),       32'(e.pc_en));
    check("if_valid",    32'(bus3.if_valid_o),    32'(e.if_valid));
    check("flush",       32'(bus3.flush_o),       32'(e.flush));
    check("halted",      32'(bus3.halted_o),      32'(e.halted));
    check("state",       32'(bus3.state_o),       32'(e.state));
    check("last_target", 32'(bus3.last_target_o), 32'(e.last_target));
    check("redirect_cnt",32'(bus3.redirect_cnt_o),32'(e.rcnt));
    check("stall_cnt",   32'(bus3.stall_cnt_o),   32'(e.scnt));

    @(posedge clk);
    if (do_rst) begin
      model_reset();
    end else begin
      if (stall && m_state != 2) m_scnt = sat_inc(m_scnt);
      case (m_state)
        0: begin
          if (halt) m_state = 2;
          else if (redir) begin
            m_rcnt = sat_inc(m_rcnt);
            m_last = tgt;
            m_state = 1;
            m_fcnt  = DEPTH - 1;
          end
        end
        1: begin
          if (!stall) begin
            if (m_fcnt == 0) m_state = 0;
            else             m_fcnt  = m_fcnt - 1;
          end
        end
        default: begin
          if (resume) m_state = 0;
        end
      endcase
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic flush_seen;
    bus3.redirect_i = 1'b0; bus3.redirect_target_i = '0; bus3.stall_req_i = 1'b0;
    bus3.halt_i = 1'b0;     bus3.resume_i = 1'b0;
    bus0.redirect_i = 1'b0; bus0.redirect_target_i = '0; bus0.stall_req_i = 1'b0;
    bus0.halt_i = 1'b0;     bus0.resume_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset values, then idle.
    check("rst_state", 32'(bus3.state_o), 32'h0);
    check("rst_valid", 32'(bus3.if_valid_o), 32'h1);
    idle(5);

    // Single redirect to 0x0040: three flush cycles then RUN.
    step(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
    check("redir_flush_lit", 32'(bus3.flush_o), 32'h1);
    idle(3);
    check("redir_run_lit", 32'(bus3.state_o), 32'h0);
    check("redir_tgt_lit", 32'(bus3.last_target_o), 32'h0040);
    check("redir_cnt_lit", 32'(bus3.redirect_cnt_o), 32'h1);
    idle(2);

    // Redirect, then stall for two flush cycles with an ignored redirect.
    step(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0,       1'b1, 1'b0, 1'b0, 1'b0);
    check("stall_flush_lit", 32'(bus3.flush_o), 32'h1);
    idle(2);
    check("stall_run_lit", 32'(bus3.state_o), 32'h0);
    check("stall_cnt_lit", 32'(bus3.stall_cnt_o), 32'h2);
    check("stall_rcnt_lit", 32'(bus3.redirect_cnt_o), 32'h2);
    check("stall_tgt_lit", 32'(bus3.last_target_o), 32'h0100);

    // Back-to-back: redirect in the first RUN cycle after a flush.
    step(1'b1, 16'h0300, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 16'h0304, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_flush_lit", 32'(bus3.flush_o), 32'h1);
    idle(4);

    // Halt and resume; stall in HALT not counted; halt in FLUSH ignored.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("halt_lit", 32'(bus3.halted_o), 32'h1);
    step(1'b1, 16'h0ABC, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(7);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("resume_lit", 32'(bus3.state_o), 32'h0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("run_both_lit", 32'(bus3.state_o), 32'h2);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("halt_both_lit", 32'(bus3.state_o), 32'h0);
    step(1'b1, 16'h0500, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);

    // Reset on the second flush cycle.
    step(1'b1, 16'h0600, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_state_lit", 32'(bus3.state_o), 32'h0);
    check("midrst_flush_lit", 32'(bus3.flush_o), 32'h0);
    check("midrst_rcnt_lit", 32'(bus3.redirect_cnt_o), 32'h0);
    check("midrst_scnt_lit", 32'(bus3.stall_cnt_o), 32'h0);
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      step(r[2:0] == 3'd0, r[31:16], r[4:3] == 2'd0, r[9:6] == 4'd0,
           r[12:10] == 3'd0, r[19:14] == 6'd0);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // FLUSH_DEPTH=0 instance: redirects never flush; counter saturates.
    flush_seen = 1'b0;
    bus0.redirect_i        = 1'b1;
    bus0.redirect_target_i = 16'h1234;
    repeat (16'hFFFE) begin
      @(posedge clk);
      #1;
      if (bus0.flush_o !== 1'b0 || bus0.state_o !== 2'b00) flush_seen = 1'b1;
    end
    check("d0_cnt_fffe", 32'(bus0.redirect_cnt_o), 32'hFFFE);
    bus0.redirect_target_i = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1;
    bus0.redirect_i = 1'b0;
    check("d0_cnt_sat", 32'(bus0.redirect_cnt_o), 32'hFFFF);
    check("d0_tgt", 32'(bus0.last_target_o), 32'hBEEF);
    check("d0_noflush", 32'(flush_seen), 32'h0);
    check("d0_valid", 32'(bus0.if_valid_o), 32'h1);
    check("d0_pc_en", 32'(bus0.pc_en_o), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
